key_debounce_multi: RTL

//   Debounces NUM_KEYS independent mechanical key inputs in the clk domain.

---
 rtl/key_debounce_multi.sv | 125 ++++++++++++
 1 files changed

// File: rtl/key_debounce_multi.sv
// Multi-key debouncer: 2-flop sync, polarity normalisation and a stability counter per key,
// registered press/release pulses. Define KEY_LONG_PRESS_EN to add a per-key long-press pulse.
module key_debounce_multi #(
    parameter int unsigned NUM_KEYS        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter bit          ACTIVE_LOW      = 1'b1,
    parameter int unsigned LONG_CYCLES     = 50000000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long
);

    localparam int unsigned          CNT_W        = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]     CNT_MAX      = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [NUM_KEYS-1:0]  RELEASED_PIN = {NUM_KEYS{ACTIVE_LOW}};

    logic [NUM_KEYS-1:0] sync1_q, sync1_d;
    logic [NUM_KEYS-1:0] sync2_q, sync2_d;
    logic [NUM_KEYS-1:0] level_q, level_d;
    logic [NUM_KEYS-1:0] press_q, press_d;
    logic [NUM_KEYS-1:0] release_q, release_d;
    logic [CNT_W-1:0]    cnt_q [NUM_KEYS];
    logic [CNT_W-1:0]    cnt_d [NUM_KEYS];
    logic [NUM_KEYS-1:0] sample;

    // Synchroniser chain; sample is the normalised level, 1 = pressed
    always_comb begin
        sync1_d = key;
        sync2_d = sync1_q;
        sample  = sync2_q ^ RELEASED_PIN;
    end

    // Any disagreement must persist DEBOUNCE_CYCLES edges; a matching sample restarts it
    always_comb begin
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < int'(NUM_KEYS); i++) begin
            cnt_d[i] = '0;
            if (sample[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    level_d[i]   = sample[i];
                    press_d[i]   = sample[i];
                    release_d[i] = ~sample[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Sync flops reset to the idle pin level so no spurious qualification follows reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q   <= RELEASED_PIN;
            sync2_q   <= RELEASED_PIN;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < int'(NUM_KEYS); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            cnt_q     <= cnt_d;
        end
    end

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;

`ifdef KEY_LONG_PRESS_EN
    localparam int unsigned       HOLD_W    = $clog2(LONG_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(LONG_CYCLES - 1);

    logic [HOLD_W-1:0]   hold_q [NUM_KEYS];
    logic [HOLD_W-1:0]   hold_d [NUM_KEYS];
    logic [NUM_KEYS-1:0] long_q, long_d;

    // Hold counter restarts on each accepted press and saturates, giving one pulse per press
    always_comb begin
        long_d = '0;
        for (int i = 0; i < int'(NUM_KEYS); i++) begin
            hold_d[i] = hold_q[i];
            if (!level_q[i] || press_d[i]) begin
                hold_d[i] = '0;
            end else if (hold_q[i] < HOLD_MAX) begin
                hold_d[i] = hold_q[i] + HOLD_W'(1);
                long_d[i] = (hold_q[i] == HOLD_FIRE) && !release_d[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            long_q <= '0;
            for (int i = 0; i < int'(NUM_KEYS); i++) begin
                hold_q[i] <= '0;
            end
        end else begin
            long_q <= long_d;
            hold_q <= hold_d;
        end
    end

    assign key_long = long_q;
`else
    localparam bit LONG_CFG_OK = (LONG_CYCLES >= 1);

    // Long-press feature absent: output is a constant 0
    assign key_long = {NUM_KEYS{1'b0}} & {NUM_KEYS{LONG_CFG_OK}};
`endif

endmodule
